fb_writer: RTL

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_writer_if.sv | 33 +++
 rtl/fb_writer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg -- definitions shared by the frame-buffer writer and the display path.
//   fb_state_e : writer FSM state encoding
//   FB_*       : default frame geometry, pixel width and video-memory address width
package fb_pkg;

   localparam int unsigned FB_WIDTH  = 200;
   localparam int unsigned FB_HEIGHT = 200;
   localparam int unsigned FB_ADDR_W = 16;
   localparam int unsigned FB_PIX_W  = 8;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } fb_state_e;

endpackage : fb_pkg

// File: rtl/fb_writer_if.sv
// fb_writer_if -- pixel stream in, video-RAM write port out.
//   in_valid/in_ready/in_data/in_sof : upstream pixel beats
//   wr_en/wr_addr/wr_data            : single-port video RAM write side
//   modport slave  : the frame-buffer writer
//   modport master : the upstream source plus the RAM it feeds
//
// Handshake: a beat transfers on every rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on writer state, never on
// in_valid, so a source may raise in_valid at any time and must hold
// in_data/in_sof stable until the transfer edge. The write port has no
// back-pressure: wr_en is a one-cycle strobe the RAM always accepts.
interface fb_writer_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned PIX_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [PIX_W-1:0]  in_data;
   logic              in_sof;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   modport slave (
      input  in_valid, in_data, in_sof,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output in_valid, in_data, in_sof,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface : fb_writer_if

// File: rtl/fb_writer.sv
// fb_writer -- writes a raster pixel stream into linear video memory
// (address = y*WIDTH + x), one pixel per accepted beat, 1-cycle write latency.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : fb_writer_if.slave (pixel stream in, RAM write port out)
//   frame_done : one-cycle pulse with the write of the last pixel
//   sof_err    : one-cycle pulse when in_sof arrives mid-frame
//   busy       : high while clearing or writing a frame
//   state_dbg  : current FSM state
// Optional feature: define FB_WRITER_CLEAR_EN to zero the whole frame after
// reset (one address per cycle) before the first frame is accepted.
module fb_writer
   import fb_pkg::*;
#(
   parameter int unsigned WIDTH  = FB_WIDTH,
   parameter int unsigned HEIGHT = FB_HEIGHT,
   parameter int unsigned ADDR_W = FB_ADDR_W,
   parameter int unsigned PIX_W  = FB_PIX_W
)(
   input  logic       clk,
   input  logic       rst,
   fb_writer_if.slave bus,
   output logic       frame_done,
   output logic       sof_err,
   output logic       busy,
   output fb_state_e  state_dbg
);

   localparam int unsigned       NPIX = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

   if (longint'(WIDTH) * longint'(HEIGHT) > (longint'(1) << ADDR_W)) begin : g_size_chk
      $error("fb_writer: WIDTH*HEIGHT does not fit in ADDR_W address bits");
   end

   fb_state_e         state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic              wr_en_nx;
   logic [ADDR_W-1:0] wr_addr_nx;
   logic [PIX_W-1:0]  wr_data_nx;
   logic              frame_done_nx, sof_err_nx;
   logic              in_ready;
   logic              accept;

   assign in_ready     = (state == ST_IDLE) || (state == ST_WRITE);
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid && in_ready;
   assign state_dbg    = state;

`ifdef FB_WRITER_CLEAR_EN
   assign busy = (state == ST_CLEAR) || (state == ST_WRITE);
`else
   assign busy = (state == ST_WRITE);
`endif

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      wr_en_nx      = 1'b0;
      wr_addr_nx    = bus.wr_addr;
      wr_data_nx    = bus.wr_data;
      frame_done_nx = 1'b0;
      sof_err_nx    = 1'b0;
      case (state)
`ifdef FB_WRITER_CLEAR_EN
         ST_CLEAR: begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = cnt;
            wr_data_nx = '0;
            if (cnt == LAST) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
`endif
         ST_IDLE: begin
            // Beats without in_sof are dropped until a frame start is seen.
            if (accept && bus.in_sof) begin
               wr_en_nx   = 1'b1;
               wr_addr_nx = '0;
               wr_data_nx = bus.in_data;
               if (LAST == '0) begin
                  // Single-pixel frame: the start pixel is also the last.
                  state_nx      = ST_DONE;
                  frame_done_nx = 1'b1;
                  cnt_nx        = '0;
               end else begin
                  state_nx = ST_WRITE;
                  cnt_nx   = ADDR_W'(1);
               end
            end
         end
         ST_WRITE: begin
            if (accept) begin
               wr_en_nx   = 1'b1;
               wr_data_nx = bus.in_data;
               // A restart wins over completion, even on the last pixel.
               if (bus.in_sof) begin
                  wr_addr_nx = '0;
                  sof_err_nx = 1'b1;
                  cnt_nx     = ADDR_W'(1);
               end else begin
                  wr_addr_nx = cnt;
                  if (cnt == LAST) begin
                     state_nx      = ST_DONE;
                     frame_done_nx = 1'b1;
                     cnt_nx        = '0;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef FB_WRITER_CLEAR_EN
         state <= ST_CLEAR;
`else
         state <= ST_IDLE;
`endif
         cnt         <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         frame_done  <= 1'b0;
         sof_err     <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         bus.wr_en   <= wr_en_nx;
         bus.wr_addr <= wr_addr_nx;
         bus.wr_data <= wr_data_nx;
         frame_done  <= frame_done_nx;
         sof_err     <= sof_err_nx;
      end
   end

endmodule : fb_writer
